grf_writeback: RTL

- General register file for the single-cycle CPU. Sits directly downstream of the write-address select stage and consumes its 5-bit destination address, the write data and the write enable.
- Holds 32 x 32-bit registers with two combinational read ports and one synchronous write port.
- Register $0 is hardwired to zero.
- Adds a registered write-back trace channel and a retired-write counter, used by the test harness for commit logging ("@pc: $addr <= data").

---
 rtl/grf_writeback.sv | 85 ++++++++
 1 files changed

// File: rtl/grf_writeback.sv
// 32 x 32-bit general register file with two combinational read ports, one write port,
// a registered write-back trace channel and a retired-write counter for commit logging.
module grf_writeback #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [31:0]      wd,
    input  logic [31:0]      pc,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0] regs [32];
    logic        commit;
    logic        wr_en;

    // $0 writes still count as commits so the log matches the reference simulator.
    assign commit = we;
    assign wr_en  = we && (wa != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == 5'd0) begin
            rd1 = 32'd0;
        end else if ((BYPASS != 0) && wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == 5'd0) begin
            rd2 = 32'd0;
        end else if ((BYPASS != 0) && wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

    // Trace payload holds its last value between commits; only trace_valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= 32'd0;
            trace_addr  <= 5'd0;
            trace_data  <= 32'd0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_pc   <= pc;
                trace_addr <= wa;
                trace_data <= wd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule
